// File: rtl/johnson4_decoder.sv
// ---------------------------------------------------------------------------
// johnson4_decoder
// Receive-side decoder for a 4-bit Johnson-coded bus. Decodes the code to a
// binary index, checks that each sampled transition is a hold or a single
// +1/-1 step (mod 8), tracks count direction and a wrapping position, and
// flags illegal codes / skipped steps with a pulse and a saturating counter.
//
// Ports:
//   clk      in   clock, all state updates on rising edge
//   clear    in   synchronous active-high reset, priority over all inputs
//   en       in   sample qualifier for j_in
//   j_in     in   [3:0] Johnson-coded input
//   idx      out  [2:0] index of last legal code accepted
//   code_ok  out  last sampled code was legal
//   locked   out  decoder is tracking
//   step     out  one-cycle pulse on an accepted +1/-1 step
//   dir      out  direction of last accepted step (1=up, 0=down)
//   pos      out  [POS_W-1:0] wrapping position count
//   err      out  one-cycle pulse on illegal code or skipped step
//   err_cnt  out  [ERR_W-1:0] saturating error count
// ---------------------------------------------------------------------------
module johnson4_decoder #(
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [3:0]       j_in,
    output logic [2:0]       idx,
    output logic             code_ok,
    output logic             locked,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Returns {legal, index}; illegal codes decode to {0, 0}.
    function automatic logic [3:0] decode_code(input logic [3:0] j);
        case (j)
            4'b0000: decode_code = {1'b1, 3'd0};
            4'b0001: decode_code = {1'b1, 3'd1};
            4'b0011: decode_code = {1'b1, 3'd2};
            4'b0111: decode_code = {1'b1, 3'd3};
            4'b1111: decode_code = {1'b1, 3'd4};
            4'b1110: decode_code = {1'b1, 3'd5};
            4'b1100: decode_code = {1'b1, 3'd6};
            4'b1000: decode_code = {1'b1, 3'd7};
            default: decode_code = {1'b0, 3'd0};
        endcase
    endfunction

    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             code_ok_q, code_ok_d;
    logic             locked_q, locked_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0]       dec_s;
    logic             legal_s;
    logic [2:0]       new_idx_s;
    logic [2:0]       delta_s;

    // Next-state and output decode for the IDLE/TRACK/FAULT tracker.
    always_comb begin
        dec_s     = decode_code(j_in);
        legal_s   = dec_s[3];
        new_idx_s = dec_s[2:0];
        // Modulo-8 difference: 1 = up step, 7 = down step, 0 = hold.
        delta_s   = new_idx_s - idx_q;

        state_d   = state_q;
        idx_d     = idx_q;
        code_ok_d = code_ok_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        pos_d     = pos_q;
        err_d     = 1'b0;

        if (en) begin
            code_ok_d = legal_s;
            case (state_q)
                IDLE, FAULT: begin
                    if (legal_s) begin
                        state_d = TRACK;
                        idx_d   = new_idx_s;
                    end else begin
                        state_d = state_q;
                        err_d   = 1'b1;
                    end
                end
                TRACK: begin
                    if (!legal_s) begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end else if (delta_s == 3'd0) begin
                        state_d = TRACK;
                    end else if (delta_s == 3'd1) begin
                        idx_d  = new_idx_s;
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos_q + POS_ONE;
                    end else if (delta_s == 3'd7) begin
                        idx_d  = new_idx_s;
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos_q - POS_ONE;
                    end else begin
                        // Skipped step: idx keeps the last trusted value.
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        locked_d = (state_d == TRACK);
    end

    // State and registered outputs with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            code_ok_q <= 1'b0;
            locked_q  <= 1'b0;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            pos_q     <= {POS_W{1'b0}};
            err_q     <= 1'b0;
            err_cnt_q <= {ERR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            code_ok_q <= code_ok_d;
            locked_q  <= locked_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign idx     = idx_q;
    assign code_ok = code_ok_q;
    assign locked  = locked_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign pos     = pos_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_johnson4_decoder.sv
// ---------------------------------------------------------------------------
// tb_johnson4_decoder
// Directed stimulus with hand-computed expectations. The driver pushes the
// expected post-edge output vector into a queue; a monitor pops one entry per
// clock edge and compares it against the DUT outputs.
// Expected vector layout: {idx[2:0], code_ok, locked, step, dir, pos[7:0],
//                          err, err_cnt[3:0]}
// ---------------------------------------------------------------------------
module tb_johnson4_decoder;

    logic       clk;
    logic       clear;
    logic       en;
    logic [3:0] j_in;
    logic [2:0] idx;
    logic       code_ok;
    logic       locked;
    logic       step;
    logic       dir;
    logic [7:0] pos;
    logic       err;
    logic [3:0] err_cnt;

    typedef struct {
        logic [20:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    johnson4_decoder #(.POS_W(8), .ERR_W(4)) dut (
        .clk     (clk),
        .clear   (clear),
        .en      (en),
        .j_in    (j_in),
        .idx     (idx),
        .code_ok (code_ok),
        .locked  (locked),
        .step    (step),
        .dir     (dir),
        .pos     (pos),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample just after a rising edge and queue the expected
    // outputs that should appear after the following edge.
    task automatic smp(input logic c, input logic e, input logic [3:0] j,
                       input logic [2:0] ei, input logic eo, input logic el,
                       input logic es, input logic ed, input logic [7:0] ep,
                       input logic ee, input logic [3:0] ec, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        clear = c;
        en    = e;
        j_in  = j;
        x.v    = {ei, eo, el, es, ed, ep, ee, ec};
        x.name = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: one expected entry per edge, checked 3 time units later.
    always @(posedge clk) begin
        exp_t        x;
        logic [20:0] act;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            #3;
            act = {idx, code_ok, locked, step, dir, pos, err, err_cnt};
            total = total + 1;
            if (act !== x.v) begin
                bad = bad + 1;
                $display("FAIL %s: got=%h expected=%h (idx,ok,lock,step,dir,pos,err,cnt) ptime=%0t",
                         x.name, act, x.v, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] up_c [8];
        total = 0;
        bad   = 0;
        clear = 1'b1;
        en    = 1'b0;
        j_in  = 4'b0000;
        up_c  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                  4'b1110, 4'b1100, 4'b1000, 4'b0000};

        // Reset with illegal code and en=1 on the clear cycle.
        smp(1'b1, 1'b1, 4'b0101, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "reset");

        // Up count through a full revolution.
        smp(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "up_lock");
        for (int i = 0; i < 8; i++) begin
            smp(1'b0, 1'b1, up_c[i], 3'(i + 1), 1'b1, 1'b1, 1'b1, 1'b1,
                8'(i + 1), 1'b0, 4'd0, "up_step");
        end

        // Down count from pos 0 wraps below zero.
        smp(1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "dn_clear");
        smp(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "dn_lock");
        smp(1'b0, 1'b1, 4'b1000, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0, 4'd0, "dn_step7");
        smp(1'b0, 1'b1, 4'b1100, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 8'd254, 1'b0, 4'd0, "dn_step6");
        smp(1'b0, 1'b1, 4'b1110, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd253, 1'b0, 4'd0, "dn_step5");
        smp(1'b0, 1'b1, 4'b1110, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd253, 1'b0, 4'd0, "dn_hold");

        // Fault on illegal code and relock.
        smp(1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "flt_clear");
        smp(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "flt_lock");
        smp(1'b0, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 4'd0, "flt_s1");
        smp(1'b0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 4'd0, "flt_s2");
        smp(1'b0, 1'b1, 4'b0101, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 4'd1, "flt_illegal");
        smp(1'b0, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 4'd1, "flt_relock");

        // Skipped step then saturation of the error counter.
        smp(1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "skp_clear");
        smp(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "skp_lock");
        smp(1'b0, 1'b1, 4'b0111, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 4'd1, "skp_delta3");
        for (int k = 1; k <= 20; k++) begin
            smp(1'b0, 1'b1, 4'b0101, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1,
                ((k + 1) > 15) ? 4'd15 : 4'(k + 1), "sat_err");
        end

        // en=0 freezes everything; pulses drop.
        smp(1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd15, "gate0");
        smp(1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd15, "gate1");
        smp(1'b0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd15, "gate2");
        smp(1'b0, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd15, "sat_relock");

        // Stalled source produces no pulses.
        smp(1'b1, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "stl_clear");
        smp(1'b0, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "stl_a");
        smp(1'b0, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "stl_b");
        smp(1'b0, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "stl_c");

        // Run up to pos 5 (with an en=0 gap after a step), then clear.
        smp(1'b0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 4'd0, "run1");
        smp(1'b0, 1'b0, 4'b0101, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 4'd0, "run_gate");
        smp(1'b0, 1'b1, 4'b0111, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 4'd0, "run2");
        smp(1'b0, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 4'd0, "run3");
        smp(1'b0, 1'b1, 4'b1110, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 4'd0, "run4");
        smp(1'b0, 1'b1, 4'b1100, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 4'd0, "run5");
        smp(1'b1, 1'b1, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, "mid_clear");

        // Let the monitor drain the queue, bounded.
        for (int w = 0; w < 10; w++) begin
            if (exp_q.size() != 0) begin
                @(posedge clk);
            end
        end
        #5;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
